// File: rtl/uart_rx_framer_pkg.sv
// Shared UART definitions: baud divisor derivation, frame sizing and the
// receiver state encoding, common to the receive and transmit sides.
package uart_rx_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    localparam int CNT_W = 16;

    function automatic int calc_divisor(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    function automatic int calc_half(input int divisor);
        return divisor / 2;
    endfunction

    function automatic int calc_frame_bits(input int num_bytes);
        return 8 * num_bytes;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Bit-level 8N1 receiver: input synchronizer, start/data/stop sampling,
// break hold-off, and one-cycle byte strobe / stop-error pulses.
module uart_rx_byte
    import uart_rx_framer_pkg::*;
#(
    parameter int DIVISOR = 16,
    parameter int HALF    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_strobe,
    output logic       stop_err,
    output logic       active,
    output logic       start_det
);

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    logic             rx_meta_r;
    logic             rx_sync_r;
    rx_state_e        state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       bit_idx_r, bit_idx_s;
    logic [7:0]       data_r, data_s;
    logic             strobe_r, strobe_s;
    logic             err_r, err_s;
    logic             active_r;

    // Two-flop synchronizer on the asynchronous serial line, idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Next-state and sampling decisions for the bit-level FSM.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        bit_idx_s = bit_idx_r;
        data_s    = data_r;
        strobe_s  = 1'b0;
        err_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s     = '0;
                bit_idx_s = 3'd0;
                if (!rx_sync_r) state_s = ST_START;
                else            state_s = ST_IDLE;
            end
            ST_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_s = '0;
                    // a start bit that is gone by mid-bit was a glitch
                    if (!rx_sync_r) state_s = ST_DATA;
                    else            state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_r == DIV_LAST) begin
                    cnt_s             = '0;
                    data_s[bit_idx_r] = rx_sync_r;
                    bit_idx_s         = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) state_s = ST_STOP;
                    else                   state_s = ST_DATA;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_r == DIV_LAST) begin
                    cnt_s = '0;
                    if (rx_sync_r) begin
                        strobe_s = 1'b1;
                        state_s  = ST_IDLE;
                    end else begin
                        err_s   = 1'b1;
                        state_s = ST_BREAK;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_BREAK: begin
                cnt_s = '0;
                if (rx_sync_r) state_s = ST_IDLE;
                else           state_s = ST_BREAK;
            end
            default: begin
                state_s   = ST_IDLE;
                cnt_s     = '0;
                bit_idx_s = 3'd0;
            end
        endcase
    end

    // FSM state, counters and registered pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            data_r    <= 8'h00;
            strobe_r  <= 1'b0;
            err_r     <= 1'b0;
            active_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_idx_r <= bit_idx_s;
            data_r    <= data_s;
            strobe_r  <= strobe_s;
            err_r     <= err_s;
            active_r  <= (state_s != ST_IDLE);
        end
    end

    assign byte_data   = data_r;
    assign byte_strobe = strobe_r;
    assign stop_err    = err_r;
    assign active      = active_r;
    assign start_det   = (state_r == ST_IDLE) && !rx_sync_r;

endmodule

// File: rtl/uart_rx_framer.sv
// Assembles NUM_BYTES received bytes into a frame, publishes complete frames
// on data_out and discards partial frames on stop errors or idle timeout.
module uart_rx_framer
    import uart_rx_framer_pkg::*;
#(
    parameter int CLOCK_FREQ   = 100_000_000,
    parameter int BAUD_RATE    = 9600,
    parameter int NUM_BYTES    = 50,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    output logic [8*NUM_BYTES-1:0] data_out,
    output logic                   frame_valid,
    output logic                   frame_err,
    output logic                   timeout,
    output logic                   busy
);

    localparam int FRAME_BITS = calc_frame_bits(NUM_BYTES);
    localparam int DIVISOR    = calc_divisor(CLOCK_FREQ, BAUD_RATE);
    localparam int HALF       = calc_half(DIVISOR);
    localparam int IDLE_LIMIT = TIMEOUT_BITS * DIVISOR;
    localparam int IDLE_W     = ($clog2(IDLE_LIMIT + 1) > 20) ? $clog2(IDLE_LIMIT + 1) : 20;
    localparam int IDX_W      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BYTES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_LIMIT - 1);

    logic [7:0]            byte_data;
    logic                  byte_strobe;
    logic                  stop_err;
    logic                  rx_active;
    logic                  start_det;

    logic [IDX_W-1:0]      byte_idx_r, byte_idx_s;
    logic [FRAME_BITS-1:0] asm_r, asm_s;
    logic [FRAME_BITS-1:0] data_out_r, data_out_s;
    logic [IDLE_W-1:0]     idle_cnt_r, idle_cnt_s;
    logic                  fv_r, fv_s;
    logic                  fe_r, fe_s;
    logic                  to_r, to_s;
    logic                  held_r, held_s;

    uart_rx_byte #(
        .DIVISOR (DIVISOR),
        .HALF    (HALF)
    ) u_rx_byte (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .byte_data   (byte_data),
        .byte_strobe (byte_strobe),
        .stop_err    (stop_err),
        .active      (rx_active),
        .start_det   (start_det)
    );

    // Frame assembly, publication and inter-byte idle supervision.
    always_comb begin
        byte_idx_s = byte_idx_r;
        asm_s      = asm_r;
        data_out_s = data_out_r;
        idle_cnt_s = '0;
        fv_s       = 1'b0;
        fe_s       = 1'b0;
        to_s       = 1'b0;
        if (byte_strobe) begin
            asm_s[8*int'(byte_idx_r) +: 8] = byte_data;
            if (byte_idx_r == LAST_IDX) begin
                data_out_s = asm_s;
                fv_s       = 1'b1;
                byte_idx_s = '0;
                asm_s      = '0;
            end else begin
                byte_idx_s = byte_idx_r + IDX_W'(1);
            end
        end else if (stop_err) begin
            fe_s       = 1'b1;
            byte_idx_s = '0;
            asm_s      = '0;
        end else if (rx_active || start_det || (byte_idx_r == '0)) begin
            idle_cnt_s = '0;
        end else if (idle_cnt_r == IDLE_LAST) begin
            to_s       = 1'b1;
            byte_idx_s = '0;
            asm_s      = '0;
        end else begin
            idle_cnt_s = idle_cnt_r + IDLE_W'(1);
        end
        held_s = (byte_idx_s != '0);
    end

    // Framing registers and one-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx_r <= '0;
            asm_r      <= '0;
            data_out_r <= '0;
            idle_cnt_r <= '0;
            fv_r       <= 1'b0;
            fe_r       <= 1'b0;
            to_r       <= 1'b0;
            held_r     <= 1'b0;
        end else begin
            byte_idx_r <= byte_idx_s;
            asm_r      <= asm_s;
            data_out_r <= data_out_s;
            idle_cnt_r <= idle_cnt_s;
            fv_r       <= fv_s;
            fe_r       <= fe_s;
            to_r       <= to_s;
            held_r     <= held_s;
        end
    end

    assign data_out    = data_out_r;
    assign frame_valid = fv_r;
    assign frame_err   = fe_r;
    assign timeout     = to_r;
    assign busy        = rx_active || held_r;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed self-checking bench for uart_rx_framer at 16 clocks per bit.
module tb_uart_rx_framer;

    localparam int NB  = 50;
    localparam int FB  = 8 * NB;
    localparam int DIV = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic [FB-1:0] data_out;
    logic          frame_valid;
    logic          frame_err;
    logic          timeout;
    logic          busy;

    int n_cmp   = 0;
    int n_fail  = 0;
    int fv_cyc  = 0;
    int fe_cyc  = 0;
    int to_cyc  = 0;
    int overlap = 0;

    uart_rx_framer #(
        .CLOCK_FREQ   (1_600_000),
        .BAUD_RATE    (100_000),
        .NUM_BYTES    (NB),
        .TIMEOUT_BITS (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .data_out    (data_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .timeout     (timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Pulse monitor: cycles each flag is high, and cycles with more than one.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_cyc++;
        if (frame_err === 1'b1)   fe_cyc++;
        if (timeout === 1'b1)     to_cyc++;
        if ((int'(frame_valid === 1'b1) + int'(frame_err === 1'b1) + int'(timeout === 1'b1)) > 1)
            overlap++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_vec(input string tag, input logic [FB-1:0] obs, input logic [FB-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(DIV);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    // Serial transmitter: shifts out {stop, data, start} words with no gap.
    task automatic uart_tx_frame(input logic [FB-1:0] f);
        logic [9:0] word;
        for (int k = 0; k < NB; k++) begin
            word = {1'b1, f[8*k +: 8], 1'b0};
            for (int b = 0; b < 10; b++) begin
                send_bit(word[0]);
                word = {1'b1, word[9:1]};
            end
        end
    endtask

    logic [FB-1:0] exp1, exp2, exp3, exp4;
    int fv0, fe0, to0, w;

    initial begin
        for (int k = 0; k < NB; k++) begin
            exp1[8*k +: 8] = 8'(k);
            exp2[8*k +: 8] = 8'(k * 7 + 3);
            exp3[8*k +: 8] = 8'(k) ^ 8'hC3;
            exp4[8*k +: 8] = 8'h5A;
        end

        rx  = 1'b1;
        rst = 1'b1;
        tick(3);
        check_vec("rst_data", data_out, '0);
        check_bit("rst_fv", frame_valid, 1'b0);
        check_bit("rst_fe", frame_err, 1'b0);
        check_bit("rst_to", timeout, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick(4);
        check_bit("idle_busy", busy, 1'b0);

        fv0 = fv_cyc;
        uart_tx_frame(exp1);
        tick(4);
        check_vec("f1_data", data_out, exp1);
        check_int("f1_lo", int'(data_out[7:0]), 32'h00);
        check_int("f1_hi", int'(data_out[399:392]), 32'h31);
        check_int("f1_fv", fv_cyc - fv0, 1);
        check_bit("f1_busy", busy, 1'b0);

        fv0 = fv_cyc; fe0 = fe_cyc; to0 = to_cyc;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        check_bit("glitch_busy_hi", busy, 1'b1);
        tick(30);
        check_bit("glitch_busy_lo", busy, 1'b0);
        check_int("glitch_pulses", (fv_cyc - fv0) + (fe_cyc - fe0) + (to_cyc - to0), 0);
        check_vec("glitch_data", data_out, exp1);

        fv0 = fv_cyc; fe0 = fe_cyc; to0 = to_cyc;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'hA5, 1'b0);
        tick(20);
        check_int("err_fe", fe_cyc - fe0, 1);
        check_bit("err_break_busy", busy, 1'b1);
        check_vec("err_data", data_out, exp1);
        rx = 1'b1;
        tick(6);
        check_bit("err_busy_lo", busy, 1'b0);
        check_int("err_other", (fv_cyc - fv0) + (to_cyc - to0), 0);

        fv0 = fv_cyc; to0 = to_cyc;
        for (int i = 0; i < 10; i++) send_byte(8'hF0 + 8'(i), 1'b1);
        tick(300);
        check_int("to_early", to_cyc - to0, 0);
        check_bit("to_held_busy", busy, 1'b1);
        w = 0;
        while (to_cyc == to0 && w < 60) begin
            tick(1);
            w++;
        end
        check_int("to_pulse", to_cyc - to0, 1);
        tick(2);
        check_bit("to_busy_lo", busy, 1'b0);
        uart_tx_frame(exp2);
        tick(4);
        check_vec("f2_data", data_out, exp2);
        check_int("f2_fv", fv_cyc - fv0, 1);

        for (int k = 0; k < 25; k++) send_byte(exp3[8*k +: 8], 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        rx  = 1'b1;
        tick(2);
        check_vec("mrst_data", data_out, '0);
        check_bit("mrst_fv", frame_valid, 1'b0);
        check_bit("mrst_fe", frame_err, 1'b0);
        check_bit("mrst_to", timeout, 1'b0);
        check_bit("mrst_busy", busy, 1'b0);
        rst = 1'b0;
        fv0 = fv_cyc; fe0 = fe_cyc; to0 = to_cyc;
        tick(40);
        check_int("mrst_quiet", (fv_cyc - fv0) + (fe_cyc - fe0) + (to_cyc - to0), 0);
        check_bit("mrst_busy_after", busy, 1'b0);
        uart_tx_frame(exp3);
        tick(4);
        check_vec("f3_data", data_out, exp3);
        check_int("f3_fv", fv_cyc - fv0, 1);

        fv0 = fv_cyc;
        uart_tx_frame(exp4);
        tick(4);
        check_vec("loop_data", data_out, exp4);
        check_int("loop_fv", fv_cyc - fv0, 1);

        tick(10);
        check_int("total_fv", fv_cyc, 4);
        check_int("total_fe", fe_cyc, 1);
        check_int("total_to", to_cyc, 1);
        check_int("overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 Parameter CLOCK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, serial bit rate.
REQ-003 Parameter NUM_BYTES, default 50, bytes per frame; frame width FRAME_BITS = 8*NUM_BYTES (400).
REQ-004 Parameter TIMEOUT_BITS, default 20, inter-byte idle limit in bit periods.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-008 data_out  output  FRAME_BITS  last complete frame, byte k at bits [8k+7:8k].
REQ-009 frame_valid  output  1  one-cycle pulse when data_out is updated.
REQ-010 frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-011 timeout  output  1  one-cycle pulse when a partial frame is discarded on idle.
REQ-012 busy  output  1  high while a byte is being received or a partial frame is held.

Function
REQ-013 DIVISOR SHALL be CLOCK_FREQ/BAUD_RATE (integer); HALF SHALL be DIVISOR/2; bit counter SHALL be 16 bits.
REQ-014 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-015 States: IDLE, START, DATA, STOP, BREAK.
REQ-016 IDLE: synchronized rx low -> START, counter cleared.
REQ-017 START: at counter == HALF-1, rx low -> DATA with counter cleared; rx high -> IDLE (glitch rejected, nothing stored).
REQ-018 DATA: at each counter == DIVISOR-1, sample rx into bit bit_idx (0..7, LSB first); after bit 7 -> STOP.
REQ-019 STOP: at counter == DIVISOR-1, rx high -> store byte at byte_idx, go IDLE; rx low -> frame_err pulse, discard partial frame, byte_idx <= 0, go BREAK.
REQ-020 BREAK: remain until synchronized rx high, then IDLE.
REQ-021 Byte store with byte_idx == NUM_BYTES-1 SHALL copy the assembled frame (including this byte) to data_out, pulse frame_valid the next cycle, and clear byte_idx; otherwise byte_idx increments.
REQ-022 data_out SHALL hold its value until the next complete frame; partial or errored frames never modify it.
REQ-023 In IDLE with byte_idx > 0, an idle counter SHALL count cycles; reaching TIMEOUT_BITS*DIVISOR SHALL pulse timeout, clear byte_idx and assembly register; counter clears on every start-bit detection (20-bit counter minimum).
REQ-024 frame_valid, frame_err and timeout SHALL be mutually exclusive in any cycle and never held beyond one cycle.
REQ-025 busy SHALL be high in START, DATA, STOP, BREAK, or IDLE with byte_idx > 0; low otherwise.
REQ-026 Back-to-back frames with zero inter-byte gap SHALL be received without loss; start edge of the next byte is accepted the cycle after STOP completes.

Reset
REQ-027 rst SHALL force state IDLE, synchronizer flops to 1, data_out 0, frame_valid/frame_err/timeout/busy 0, byte_idx/bit_idx/counters 0, assembly register 0.
REQ-028 rst asserted mid-byte or mid-frame SHALL discard all partial data with no output pulse after release.

Structure
REQ-029 Shared package SHALL hold DIVISOR/HALF derivation, FRAME_BITS, and the state encoding, shared with the transmitter side.
REQ-030 Bit-level reception (synchronizer, START/DATA/STOP/BREAK, byte strobe, stop error) SHALL be a sub-module uart_rx_byte; framing, timeout and data_out live in the top.

Verification (bench overrides CLOCK_FREQ=1_600_000, BAUD_RATE=100_000 -> DIVISOR 16, HALF 8)
REQ-031 Send 50 bytes 0x00..0x31 back-to-back -> single frame_valid pulse; data_out[7:0]=0x00, [399:392]=0x31.
REQ-032 Byte 0xA5 with stop bit driven low -> frame_err pulse one cycle, state BREAK until rx high, data_out unchanged.
REQ-033 rx low pulse of 4 cycles in IDLE -> no byte stored, busy returns low, no output pulse.
REQ-034 Send 10 bytes then idle 20*16=320 cycles -> timeout pulse, busy low; following 50-byte frame assembles from byte 0.
REQ-035 Assert rst during byte 25 of a frame -> all outputs 0; subsequent full frame produces correct data_out.
REQ-036 Loopback: UART transmitter sending 400-bit pattern 0x5A repeated -> data_out equals the sent pattern, one frame_valid.
